// File: rtl/instr_word_encoder_if.sv
// Loader command bus plus instruction-memory write port for instr_word_encoder.
// The slave modport is the encoder's view; master is the loader/memory side.
interface instr_word_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [3:0]        cmd_cond;
    logic              cmd_imm;
    logic [3:0]        cmd_fn;
    logic              cmd_sl;
    logic [3:0]        cmd_rn;
    logic [3:0]        cmd_rd;
    logic [11:0]       cmd_src2;
    logic [23:0]       cmd_imm24;
    logic              imem_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_type, cmd_cond, cmd_imm, cmd_fn, cmd_sl,
               cmd_rn, cmd_rd, cmd_src2, cmd_imm24, imem_ready,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_cond, cmd_imm, cmd_fn, cmd_sl,
               cmd_rn, cmd_rd, cmd_src2, cmd_imm24, imem_ready,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs loader commands into 32-bit instruction words, queues them, writes them to imem in order.
// Accept-to-write latency 1 cycle; cmd_ready drops on full FIFO or exhausted address space, imem_ready stalls writes.
module instr_word_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_start,
    input  logic                prog_end,
    instr_word_encoder_if.slave bus,
    output logic                prog_done,
    output logic [ADDR_W:0]     word_count,
    output logic                err_illegal,
    output logic                err_overflow
);
    localparam int PW   = $clog2(DEPTH);
    localparam int SPAN = (1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              ill_q, ill_d, ovf_q, ovf_d;
    logic              fifo_full, fifo_empty, addr_exhausted;
    logic              in_load, accept, push, wr_en;
    logic [ADDR_W+1:0] used;
    logic [31:0]       enc_word;

    always_comb begin
        if (bus.cmd_type == 2'b10) begin
            enc_word = {bus.cmd_cond, 2'b10, 2'b10, bus.cmd_imm24};
        end else begin
            enc_word = {bus.cmd_cond, bus.cmd_type, bus.cmd_imm, bus.cmd_fn, bus.cmd_sl,
                        bus.cmd_rn, bus.cmd_rd, bus.cmd_src2};
        end
    end

    // Words already written plus words still queued must never exceed the address window.
    assign used           = {1'b0, wc_q} + (ADDR_W+2)'(cnt_q);
    assign addr_exhausted = (used == (ADDR_W+2)'(SPAN));
    assign fifo_full      = (cnt_q == (PW+1)'(DEPTH));
    assign fifo_empty     = (cnt_q == '0);
    assign in_load        = (state_q == LOAD);

    assign bus.cmd_ready  = in_load & ~fifo_full & ~addr_exhausted & ~prog_start;
    assign accept         = bus.cmd_valid & bus.cmd_ready;
    assign push           = accept & (bus.cmd_type != 2'b11);
    assign wr_en          = (in_load | (state_q == DRAIN)) & ~fifo_empty & bus.imem_ready;

    assign bus.imem_we    = wr_en;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = mem_q[rd_ptr_q];
    assign prog_done      = (state_q == DONE);
    assign word_count     = wc_q;
    assign err_illegal    = ill_q;
    assign err_overflow   = ovf_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wc_d     = wc_q;
        ill_d    = ill_q;
        ovf_d    = ovf_q;
        if (prog_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            addr_d   = ADDR_W'(BASE_ADDR);
            wc_d     = '0;
            ill_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                wc_d     = wc_q + 1'b1;
                // Saturate rather than wrap; exhaustion blocks any further write anyway.
                if (addr_q != {ADDR_W{1'b1}}) addr_d = addr_q + 1'b1;
            end
            case ({push, wr_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (accept && bus.cmd_type == 2'b11) ill_d = 1'b1;
            if (in_load && bus.cmd_valid && addr_exhausted) ovf_d = 1'b1;
            case (state_q)
                IDLE:    state_d = IDLE;
                LOAD:    if (prog_end) state_d = DRAIN;
                DRAIN:   if (fifo_empty) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            wc_q     <= '0;
            ill_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            ill_q    <= ill_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: dut_a uses default params, dut_b uses ADDR_W=2 for exhaustion.
module tb_instr_word_encoder;
    typedef struct packed {
        logic [1:0]  typ;
        logic [3:0]  cond;
        logic        imm;
        logic [3:0]  fn;
        logic        sl;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n, prog_start, prog_end;
    logic prog_done_a, err_ill_a, err_ovf_a;
    logic prog_done_b, err_ill_b, err_ovf_b;
    logic [10:0] wc_a;
    logic [2:0]  wc_b;
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [1:0]  qb_addr[$];

    instr_word_encoder_if #(.ADDR_W(10)) ifa ();
    instr_word_encoder_if #(.ADDR_W(2))  ifb ();

    instr_word_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .prog_end(prog_end),
        .bus(ifa.slave), .prog_done(prog_done_a), .word_count(wc_a),
        .err_illegal(err_ill_a), .err_overflow(err_ovf_a)
    );

    instr_word_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .prog_end(prog_end),
        .bus(ifb.slave), .prog_done(prog_done_b), .word_count(wc_b),
        .err_illegal(err_ill_b), .err_overflow(err_ovf_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (ifa.imem_we) begin
            qa_addr.push_back(ifa.imem_addr);
            qa_data.push_back(ifa.imem_wdata);
            qa_cyc.push_back(cyc);
        end
        if (ifb.imem_we) qb_addr.push_back(ifb.imem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] typ, input logic [3:0] cond, input logic imm,
                                input logic [3:0] fn, input logic sl, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [11:0] src2, input logic [23:0] imm24);
        cmd_t c;
        c = '{typ, cond, imm, fn, sl, rn, rd, src2, imm24};
        return c;
    endfunction

    task automatic put_fields(input cmd_t c);
        ifa.cmd_type = c.typ;  ifb.cmd_type = c.typ;
        ifa.cmd_cond = c.cond; ifb.cmd_cond = c.cond;
        ifa.cmd_imm  = c.imm;  ifb.cmd_imm  = c.imm;
        ifa.cmd_fn   = c.fn;   ifb.cmd_fn   = c.fn;
        ifa.cmd_sl   = c.sl;   ifb.cmd_sl   = c.sl;
        ifa.cmd_rn   = c.rn;   ifb.cmd_rn   = c.rn;
        ifa.cmd_rd   = c.rd;   ifb.cmd_rd   = c.rd;
        ifa.cmd_src2 = c.src2; ifb.cmd_src2 = c.src2;
        ifa.cmd_imm24 = c.imm24; ifb.cmd_imm24 = c.imm24;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_cmd(input bit sel_b, input cmd_t c);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        put_fields(c);
        if (sel_b) ifb.cmd_valid = 1'b1; else ifa.cmd_valid = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = sel_b ? ifb.cmd_ready : ifa.cmd_ready;
            n++;
        end
        check("accept_wait", 64'(ok), 64'd1);
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0;
        ifb.cmd_valid = 1'b0;
    endtask

    task automatic pulse_start();
        prog_start = 1'b1;
        @(posedge clk); #1;
        prog_start = 1'b0;
    endtask

    task automatic pulse_end();
        prog_end = 1'b1;
        @(posedge clk); #1;
        prog_end = 1'b0;
    endtask

    task automatic clear_q();
        qa_addr.delete(); qa_data.delete(); qa_cyc.delete(); qb_addr.delete();
    endtask

    cmd_t d1, m1, b1, il;
    logic [31:0] exp4 [4];

    initial begin
        d1 = mk(2'b00, 4'hE, 1'b1, 4'h4, 1'b1, 4'd2, 4'd3, 12'h005, 24'h0);
        m1 = mk(2'b01, 4'hE, 1'b1, 4'b1100, 1'b1, 4'd1, 4'd4, 12'h010, 24'h0);
        b1 = mk(2'b10, 4'hE, 1'b0, 4'h0, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE);
        il = mk(2'b11, 4'hE, 1'b1, 4'hF, 1'b1, 4'd7, 4'd7, 12'hFFF, 24'h0);
        exp4 = '{32'hA1A01001, 32'hA1A02002, 32'hA1A03003, 32'hA1A04004};
        rst_n = 1'b0; prog_start = 1'b0; prog_end = 1'b0;
        ifa.cmd_valid = 1'b0; ifb.cmd_valid = 1'b0;
        ifa.imem_ready = 1'b1; ifb.imem_ready = 1'b1;
        put_fields(d1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
        check("rst_imem_we", 64'(ifa.imem_we), 64'd0);
        check("rst_prog_done", 64'(prog_done_a), 64'd0);
        check("rst_word_count", 64'(wc_a), 64'd0);
        check("rst_errs", 64'({err_ill_a, err_ovf_a}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single data command: written the cycle after acceptance.
        pulse_start();
        drive_cmd(1'b0, d1);
        @(negedge clk);
        check("t1_we", 64'(ifa.imem_we), 64'd1);
        check("t1_addr", 64'(ifa.imem_addr), 64'd0);
        check("t1_wdata", 64'(ifa.imem_wdata), 64'hE2923005);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_word_count", 64'(wc_a), 64'd1);

        // Memory then branch encodings.
        @(posedge clk); #1;
        pulse_start();
        clear_q();
        drive_cmd(1'b0, m1);
        drive_cmd(1'b0, b1);
        repeat (4) @(negedge clk);
        check("t2_nwords", 64'(qa_data.size()), 64'd2);
        if (qa_data.size() == 2) begin
            check("t2_w0", 64'(qa_data[0]), 64'hE7914010);
            check("t2_w1", 64'(qa_data[1]), 64'hEAFFFFFE);
            check("t2_a1", 64'(qa_addr[1]), 64'd1);
        end

        // Fill FIFO with memory stalled, then release.
        @(posedge clk); #1;
        pulse_start();
        clear_q();
        ifa.imem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            drive_cmd(1'b0, mk(2'b00, 4'hA, 1'b0, 4'hD, 1'b0, 4'd0, 4'(i + 1), 12'(i + 1), 24'h0));
        @(negedge clk);
        check("t3_full_ready", 64'(ifa.cmd_ready), 64'd0);
        check("t3_stalled_we", 64'(ifa.imem_we), 64'd0);
        @(posedge clk); #1;
        ifa.imem_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_nwords", 64'(qa_data.size()), 64'd4);
        if (qa_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_w%0d", i), 64'(qa_data[i]), 64'(exp4[i]));
                check($sformatf("t3_a%0d", i), 64'(qa_addr[i]), 64'(i));
                check($sformatf("t3_cyc%0d", i), 64'(qa_cyc[i] - qa_cyc[0]), 64'(i));
            end
        end

        // Illegal type is consumed but never written.
        @(posedge clk); #1;
        pulse_start();
        clear_q();
        check("t4_ill_cleared", 64'(err_ill_a), 64'd0);
        drive_cmd(1'b0, d1);
        drive_cmd(1'b0, il);
        drive_cmd(1'b0, b1);
        repeat (4) @(negedge clk);
        check("t4_err_illegal", 64'(err_ill_a), 64'd1);
        check("t4_nwords", 64'(qa_data.size()), 64'd2);
        if (qa_data.size() == 2) begin
            check("t4_w0", 64'(qa_data[0]), 64'hE2923005);
            check("t4_w1", 64'(qa_data[1]), 64'hEAFFFFFE);
            check("t4_a1", 64'(qa_addr[1]), 64'd1);
        end

        // Address exhaustion on the 4-word instance.
        @(posedge clk); #1;
        pulse_start();
        clear_q();
        for (int i = 0; i < 4; i++)
            drive_cmd(1'b1, mk(2'b00, 4'hA, 1'b0, 4'hD, 1'b0, 4'd0, 4'(i + 1), 12'(i + 1), 24'h0));
        @(negedge clk);
        check("t5_exhausted_ready", 64'(ifb.cmd_ready), 64'd0);
        check("t5_ovf_before", 64'(err_ovf_b), 64'd0);
        @(posedge clk); #1;
        ifb.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_err_overflow", 64'(err_ovf_b), 64'd1);
        check("t5_still_blocked", 64'(ifb.cmd_ready), 64'd0);
        @(posedge clk); #1;
        ifb.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_nwords", 64'(qb_addr.size()), 64'd4);
        if (qb_addr.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("t5_a%0d", i), 64'(qb_addr[i]), 64'(i));
        check("t5_word_count", 64'(wc_b), 64'd4);
        check("t5_addr_nowrap", 64'(ifb.imem_addr), 64'd3);

        // Drain with stalled memory, then done pulse.
        @(posedge clk); #1;
        pulse_start();
        clear_q();
        ifa.imem_ready = 1'b0;
        drive_cmd(1'b0, m1);
        drive_cmd(1'b0, b1);
        pulse_end();
        @(negedge clk);
        check("t6_drain_ready", 64'(ifa.cmd_ready), 64'd0);
        @(posedge clk); #1;
        ifa.imem_ready = 1'b1;
        begin
            int pulses;
            logic [10:0] wc_at_done;
            pulses = 0;
            wc_at_done = '0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (prog_done_a) begin
                    if (pulses == 0) wc_at_done = wc_a;
                    pulses++;
                end
            end
            check("t6_done_pulses", 64'(pulses), 64'd1);
            check("t6_done_wc", 64'(wc_at_done), 64'd2);
        end
        check("t6_nwords", 64'(qa_data.size()), 64'd2);
        if (qa_addr.size() == 2) check("t6_a1", 64'(qa_addr[1]), 64'd1);

        // Reset during drain discards everything.
        @(posedge clk); #1;
        pulse_start();
        ifa.imem_ready = 1'b0;
        drive_cmd(1'b0, m1);
        drive_cmd(1'b0, b1);
        pulse_end();
        clear_q();
        rst_n = 1'b0;
        @(posedge clk); #1;
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        check("t7_rst_we", 64'(ifa.imem_we), 64'd0);
        check("t7_rst_ready", 64'(ifa.cmd_ready), 64'd0);
        check("t7_rst_wc", 64'(wc_a), 64'd0);
        check("t7_rst_addr", 64'(ifa.imem_addr), 64'd0);
        check("t7_rst_done", 64'(prog_done_a), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t7_no_writes", 64'(qa_data.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
